// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: bounded, restartable run controller for the multi-cycle core.
// Walks a one-hot phase through STAGES positions per instruction, counts
// cycles and retired instructions, and ends a run on halt, budget expiry or
// abort, reporting which one ended it.
module seq_run_ctrl #(
  parameter int STAGES     = 5,
  parameter int CYC_W      = 32,
  parameter int MAX_CYCLES = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              halt_in,
  input  logic              abort,
  output logic [STAGES-1:0] stage_en,
  output logic              instr_done,
  output logic              running,
  output logic              done,
  output logic [1:0]        halt_reason,
  output logic [CYC_W-1:0]  cycle_cnt,
  output logic [CYC_W-1:0]  instr_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [1:0] RSN_NONE  = 2'd0;
  localparam logic [1:0] RSN_HALT  = 2'd1;
  localparam logic [1:0] RSN_TMO   = 2'd2;
  localparam logic [1:0] RSN_ABORT = 2'd3;

  // Value of cycle_q during the final budgeted cycle; unused when unlimited.
  localparam logic [CYC_W-1:0] TMO_AT =
    CYC_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

  state_t              state_q, state_d;
  logic [1:0]          reason_q, reason_d;
  logic [STAGES-1:0]   stage_q;
  logic [CYC_W-1:0]    cycle_q, instr_q;
  logic                last_stg, tmo_hit, run_c, run_next;

  assign last_stg = stage_q[STAGES-1];
  assign tmo_hit  = (MAX_CYCLES != 0) && (cycle_q == TMO_AT);
  assign run_next = (state_d == S_RUN) || (state_d == S_DRAIN);

  // State and end-reason registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      reason_q <= RSN_NONE;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
    end
  end

  // Next-state: abort beats timeout beats halt completion beats drain entry.
  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_RUN;
          reason_d = RSN_NONE;
        end
      end
      S_RUN, S_DRAIN: begin
        if (abort) begin
          state_d  = S_DONE;
          reason_d = RSN_ABORT;
        end else if (tmo_hit) begin
          state_d  = S_DONE;
          reason_d = RSN_TMO;
        end else if (last_stg && (state_q == S_DRAIN || halt_in)) begin
          state_d  = S_DONE;
          reason_d = RSN_HALT;
        end else if (state_q == S_RUN && halt_in) begin
          state_d  = S_DRAIN;
        end
      end
      default: begin
        state_d  = S_IDLE;
        reason_d = RSN_NONE;
      end
    endcase
  end

  // Status outputs decoded from state; stage_q is already zero when idle.
  always_comb begin
    run_c       = (state_q == S_RUN) || (state_q == S_DRAIN);
    running     = run_c;
    done        = (state_q == S_DONE);
    instr_done  = run_c & last_stg;
    stage_en    = stage_q;
    halt_reason = reason_q;
    cycle_cnt   = cycle_q;
    instr_cnt   = instr_q;
  end

  // Phase rotation and saturating counters; terminating cycle still counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      cycle_q <= '0;
      instr_q <= '0;
    end else if (!run_c) begin
      if (start) begin
        stage_q <= STAGES'(1);
        cycle_q <= '0;
        instr_q <= '0;
      end
    end else begin
      cycle_q <= (cycle_q == '1) ? cycle_q : cycle_q + CYC_W'(1);
      if (last_stg && instr_q != '1)
        instr_q <= instr_q + CYC_W'(1);
      stage_q <= run_next ? {stage_q[STAGES-2:0], stage_q[STAGES-1]} : '0;
    end
  end

endmodule
